// File: rtl/tempsens_meas_seq.sv
// Multi-channel delay-line sensor sequencer: precharge, time each channel, average, subtract offset.
// One result per channel after 2^AVG_LOG2 samples; no backpressure, result_valid_o is a one-cycle strobe.
module tempsens_meas_seq #(
    parameter int N_CH     = 2,
    parameter int CNT_W    = 12,
    parameter int AVG_LOG2 = 2,
    parameter int CAL_W    = 8,
    parameter int PRECHG   = 4,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             cont_i,
    output logic [N_CH-1:0]  sens_en_o,
    input  logic [N_CH-1:0]  sens_done_i,
    input  logic             cal_clk_i,
    input  logic             cal_dat_i,
    input  logic             cal_ena_i,
    output logic [CNT_W-1:0] result_o,
    output logic [CH_W-1:0]  result_ch_o,
    output logic             result_valid_o,
    output logic             busy_o,
    output logic             timeout_o
);
    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int SMP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int PC_W  = $clog2(PRECHG + 1);
    localparam int SR_W  = N_CH * CAL_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(PRECHG - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRECHG, S_MEAS, S_ACC, S_OUT} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [SMP_W-1:0]  sample_q, sample_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  res_q, res_d;
    logic [CH_W-1:0]   res_ch_q, res_ch_d;
    logic              tmo_q, tmo_d;
    logic [N_CH-1:0]   done_s1_q, done_s2_q;
    logic [2:0]        calclk_q, calena_q;
    logic [1:0]        caldat_q;
    logic [SR_W-1:0]   shreg_q, shreg_d, offs_q, offs_d;

    logic              done_cur;
    logic [ACC_W-1:0]  acc_sum;
    logic [CNT_W-1:0]  avg, off_ext, res_calc;

    // Calibration edges are taken from the synchronised copies; data is sampled with the same lag.
    always_comb begin
        shreg_d = shreg_q;
        offs_d  = offs_q;
        if (calclk_q[1] && !calclk_q[2] && calena_q[1])
            shreg_d = SR_W'({shreg_q, caldat_q[1]});
        if (calena_q[2] && !calena_q[1])
            offs_d = shreg_q;
    end

    assign done_cur = done_s2_q[ch_q];
    assign acc_sum  = acc_q + ACC_W'(cnt_q);
    assign avg      = CNT_W'(acc_sum >> AVG_LOG2);
    assign off_ext  = CNT_W'(offs_q[int'(ch_q)*CAL_W +: CAL_W]);
    assign res_calc = (avg > off_ext) ? (avg - off_ext) : '0;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        sample_d = sample_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        res_d    = res_q;
        res_ch_d = res_ch_q;
        tmo_d    = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (start_i || cont_i) begin
                    state_d  = S_PRECHG;
                    ch_d     = '0;
                    sample_d = '0;
                    acc_d    = '0;
                    pc_d     = '0;
                    cnt_d    = '0;
                    if (start_i) tmo_d = 1'b0;
                end
            end
            S_PRECHG: begin
                cnt_d = '0;
                if (pc_q == PC_LAST) begin
                    state_d = S_MEAS;
                    cnt_d   = CNT_W'(1);
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            S_MEAS: begin
                if (done_cur || cnt_q == CNT_MAX) begin
                    state_d = S_ACC;
                    if (cnt_q == CNT_MAX) tmo_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACC: begin
                acc_d = acc_sum;
                if (sample_q == SMP_LAST) begin
                    state_d  = S_OUT;
                    res_d    = res_calc;
                    res_ch_d = ch_q;
                end else begin
                    state_d  = S_PRECHG;
                    sample_d = sample_q + 1'b1;
                    pc_d     = '0;
                end
            end
            S_OUT: begin
                sample_d = '0;
                acc_d    = '0;
                pc_d     = '0;
                if (ch_q != CH_LAST) begin
                    state_d = S_PRECHG;
                    ch_d    = ch_q + 1'b1;
                end else if (cont_i) begin
                    state_d = S_PRECHG;
                    ch_d    = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            sample_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            pc_q      <= '0;
            res_q     <= '0;
            res_ch_q  <= '0;
            tmo_q     <= 1'b0;
            done_s1_q <= '0;
            done_s2_q <= '0;
            calclk_q  <= '0;
            calena_q  <= '0;
            caldat_q  <= '0;
            shreg_q   <= '0;
            offs_q    <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            sample_q  <= sample_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            res_q     <= res_d;
            res_ch_q  <= res_ch_d;
            tmo_q     <= tmo_d;
            done_s1_q <= sens_done_i;
            done_s2_q <= done_s1_q;
            calclk_q  <= {calclk_q[1:0], cal_clk_i};
            calena_q  <= {calena_q[1:0], cal_ena_i};
            caldat_q  <= {caldat_q[0], cal_dat_i};
            shreg_q   <= shreg_d;
            offs_q    <= offs_d;
        end
    end

    always_comb begin
        sens_en_o = '0;
        if (state_q == S_MEAS) sens_en_o[ch_q] = 1'b1;
    end

    assign result_o       = res_q;
    assign result_ch_o    = res_ch_q;
    assign result_valid_o = (state_q == S_OUT);
    assign busy_o         = (state_q != S_IDLE);
    assign timeout_o      = tmo_q;
endmodule

// File: tb/tb_tempsens_meas_seq.sv
// Bench for tempsens_meas_seq: behavioural sensor cells plus a per-sweep result model.
module tb_tempsens_meas_seq;
    localparam int N_CH = 2, CNT_W = 8, AVG_LOG2 = 2, CAL_W = 8, PRECHG = 4;
    localparam int NS  = 1 << AVG_LOG2;
    localparam int SAT = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n, start_i, cont_i, cal_clk_i, cal_dat_i, cal_ena_i;
    logic [N_CH-1:0]  sens_en_o, sens_done_i;
    logic [CNT_W-1:0] result_o;
    logic [0:0]       result_ch_o;
    logic             result_valid_o, busy_o, timeout_o;

    int total = 0;
    int bad   = 0;

    int tgt [N_CH][NS];
    int k   [N_CH];
    int sc  [N_CH];
    int off [N_CH];
    bit force_hi [N_CH];
    bit never    [N_CH];
    int q_ch[$];
    int q_res[$];

    tempsens_meas_seq #(
        .N_CH(N_CH), .CNT_W(CNT_W), .AVG_LOG2(AVG_LOG2), .CAL_W(CAL_W), .PRECHG(PRECHG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .cont_i(cont_i),
        .sens_en_o(sens_en_o), .sens_done_i(sens_done_i),
        .cal_clk_i(cal_clk_i), .cal_dat_i(cal_dat_i), .cal_ena_i(cal_ena_i),
        .result_o(result_o), .result_ch_o(result_ch_o), .result_valid_o(result_valid_o),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    // Sensor cell: raises done so that the 2-flop synchronised flag appears in MEAS cycle tgt.
    always @(negedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (sens_en_o[c]) k[c] = k[c] + 1;
            else begin
                if (k[c] != 0) sc[c] = (sc[c] + 1) % NS;
                k[c] = 0;
            end
            sens_done_i[c] = force_hi[c] ||
                (sens_en_o[c] && !never[c] && (k[c] >= tgt[c][sc[c]] - 2));
        end
    end

    always @(negedge clk) begin
        if (result_valid_o) begin
            q_ch.push_back(int'(result_ch_o));
            q_res.push_back(int'(result_o));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected result: truncated mean of the samples, minus offset, floored at zero.
    function automatic int exp_res(input int c);
        int s = 0;
        for (int i = 0; i < NS; i++)
            s += force_hi[c] ? 1 : (never[c] ? SAT : tgt[c][i]);
        s = s / NS;
        return (s > off[c]) ? (s - off[c]) : 0;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        for (int c = 0; c < N_CH; c++) sc[c] = 0;
        start_i = 1'b1;
        cyc(1);
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 6000) begin cyc(1); n++; end
        chk(tag, int'(busy_o), 0);
    endtask

    task automatic check_sweep(input string tag, input int nsw);
        chk({tag, "_npulse"}, q_ch.size(), N_CH * nsw);
        for (int i = 0; i < q_ch.size() && i < N_CH * nsw; i++) begin
            chk({tag, "_ch"}, q_ch[i], i % N_CH);
            chk({tag, "_res"}, q_res[i], exp_res(i % N_CH));
        end
        q_ch.delete();
        q_res.delete();
    endtask

    task automatic run_sweep(input string tag);
        pulse_start();
        wait_idle({tag, "_idle"});
        check_sweep(tag, 1);
    endtask

    task automatic rand_tgt(input int lo, input int hi);
        for (int c = 0; c < N_CH; c++)
            for (int i = 0; i < NS; i++) tgt[c][i] = $urandom_range(hi, lo);
    endtask

    task automatic cal_load(input logic [15:0] v);
        cal_ena_i = 1'b1;
        cyc(4);
        for (int i = 15; i >= 0; i--) begin
            cal_dat_i = v[i];
            cyc(3);
            cal_clk_i = 1'b1;
            cyc(4);
            cal_clk_i = 1'b0;
            cyc(3);
        end
        cal_ena_i = 1'b0;
        cyc(5);
        off[0] = int'(v[7:0]);
        off[1] = int'(v[15:8]);
    endtask

    initial begin
        logic [31:0] rv;
        int n;
        rst_n = 1'b0; start_i = 1'b0; cont_i = 1'b0;
        cal_clk_i = 1'b0; cal_dat_i = 1'b0; cal_ena_i = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            k[c] = 0; sc[c] = 0; off[c] = 0; force_hi[c] = 1'b0; never[c] = 1'b0;
            for (int i = 0; i < NS; i++) tgt[c][i] = 50;
        end
        cyc(3);
        chk("rst_result", int'(result_o), 0);
        chk("rst_valid", int'(result_valid_o), 0);
        chk("rst_ch", int'(result_ch_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_timeout", int'(timeout_o), 0);
        chk("rst_en", int'(sens_en_o), 0);
        rst_n = 1'b1;
        cyc(2);

        // Fixed counts 100 / 200.
        for (int i = 0; i < NS; i++) begin tgt[0][i] = 100; tgt[1][i] = 200; end
        run_sweep("t1");
        chk("t1_timeout", int'(timeout_o), 0);

        // Averaging with truncation: 10,11,12,13 -> 11.
        tgt[0][0] = 10; tgt[0][1] = 11; tgt[0][2] = 12; tgt[0][3] = 13;
        for (int i = 0; i < NS; i++) tgt[1][i] = $urandom_range(150, 3);
        run_sweep("t2");

        // Done already high on entry -> every sample counts 1.
        force_hi[0] = 1'b1;
        rand_tgt(3, 150);
        run_sweep("t_donehi");
        force_hi[0] = 1'b0;
        cyc(4);

        // Offsets 0x05 (ch1) / 0x03 (ch0).
        cal_load(16'h0503);
        for (int i = 0; i < NS; i++) begin tgt[0][i] = 3; tgt[1][i] = 20; end
        run_sweep("t3");

        for (int r = 0; r < 3; r++) begin
            rv = $urandom;
            cal_load(rv[15:0] & 16'h3f3f);
            rand_tgt(3, 200);
            run_sweep("t_rand");
        end

        // Channel 0 never responds -> saturated samples, sticky timeout.
        never[0] = 1'b1;
        rand_tgt(3, 100);
        run_sweep("t4");
        chk("t4_tmo_set", int'(timeout_o), 1);
        cyc(20);
        chk("t4_tmo_hold", int'(timeout_o), 1);
        never[0] = 1'b0;
        pulse_start();
        chk("t4_tmo_clr", int'(timeout_o), 0);
        wait_idle("t4b_idle");
        check_sweep("t4b", 1);
        chk("t4b_tmo", int'(timeout_o), 0);

        // Free-run: drop cont_i during the third sweep.
        rand_tgt(3, 60);
        for (int c = 0; c < N_CH; c++) sc[c] = 0;
        cont_i = 1'b1;
        n = 0;
        while (q_ch.size() < 2 * N_CH && n < 20000) begin cyc(1); n++; end
        chk("t5_reach4", int'(q_ch.size() >= 2 * N_CH), 1);
        cont_i = 1'b0;
        wait_idle("t5_idle");
        check_sweep("t5", 3);

        // Reset during channel-1 measurement.
        for (int i = 0; i < NS; i++) begin tgt[0][i] = 40; tgt[1][i] = 150; end
        pulse_start();
        n = 0;
        while (!sens_en_o[1] && n < 3000) begin cyc(1); n++; end
        chk("t6_reach_ch1", int'(sens_en_o[1]), 1);
        cyc(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_en", int'(sens_en_o), 0);
        chk("t6_busy", int'(busy_o), 0);
        chk("t6_result", int'(result_o), 0);
        chk("t6_valid", int'(result_valid_o), 0);
        chk("t6_ch", int'(result_ch_o), 0);
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        chk("t6_npulse", q_ch.size(), 1);
        q_ch.delete();
        q_res.delete();
        off[0] = 0;
        off[1] = 0;
        rand_tgt(3, 120);
        run_sweep("t6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
